// File: rtl/notch_result_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : notch_result_packetizer
// Purpose  : Accepts float32 results from the notch filter over a
//            valid/ack handshake, queues them in a small FIFO and sends each
//            one as a 6-byte frame on a valid/ready byte stream:
//            HEADER, data[31:24], data[23:16], data[15:8], data[7:0], XOR.
// Ports    : i_CLK / i_RST        clock, synchronous active-high reset
//            i_result[31:0]       result word, held stable while valid
//            i_result_valid       producer request
//            o_result_ack         one-cycle pulse after a capture edge
//            o_byte[7:0]          frame byte
//            o_byte_valid         frame byte valid
//            i_byte_ready         downstream accepts byte
//            o_fifo_full          FIFO holds FIFO_DEPTH entries
//            o_busy               frame in progress or FIFO non-empty
// Revision : 1.0 - initial release
// ============================================================================
module notch_result_packetizer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [31:0] i_result,
  input  logic        i_result_valid,
  output logic        o_result_ack,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  input  logic        i_byte_ready,
  output logic        o_fifo_full,
  output logic        o_busy
);

  localparam int              c_AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              c_CW    = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HDR   = 2'd1,
    S_DATA  = 2'd2,
    S_CKSUM = 2'd3
  } state_t;

  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0] r_count, w_count_nxt;
  logic            r_armed, r_ack, r_fifo_full, r_busy;
  state_t          r_state, w_state_nxt;
  logic [31:0]     r_shift, w_shift_nxt;
  logic [7:0]      r_cksum, w_cksum_nxt;
  logic [7:0]      r_byte, w_byte_nxt;
  logic [1:0]      r_idx, w_idx_nxt;
  logic            r_byte_valid, w_byte_valid_nxt;
  logic            w_capture, w_pop, w_accept, w_fifo_empty;

  assign w_fifo_empty = (r_count == '0);
  assign w_accept     = r_byte_valid && i_byte_ready;
  // Fullness is judged on the pre-edge count, so a pop in the same cycle
  // never makes room for that cycle's capture.
  assign w_capture    = i_result_valid && r_armed && (r_count != c_DEPTH);

  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_cksum_nxt      = r_cksum;
    w_byte_nxt       = r_byte;
    w_idx_nxt        = r_idx;
    w_byte_valid_nxt = r_byte_valid;
    w_pop            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) w_pop = 1'b1;
      end
      S_HDR: begin
        if (w_accept) begin
          w_byte_nxt  = r_shift[31:24];
          w_cksum_nxt = r_shift[31:24];
          w_shift_nxt = {r_shift[23:0], 8'h00};
          w_idx_nxt   = 2'd0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept) begin
          w_idx_nxt = r_idx + 2'd1;
          if (r_idx != 2'd3) begin
            // The next data byte always sits at the top of the shift register.
            w_byte_nxt  = r_shift[31:24];
            w_cksum_nxt = r_cksum ^ r_shift[31:24];
            w_shift_nxt = {r_shift[23:0], 8'h00};
          end else begin
            w_byte_nxt  = r_cksum;
            w_state_nxt = S_CKSUM;
          end
        end
      end
      S_CKSUM: begin
        if (w_accept) begin
          if (!w_fifo_empty) begin
            w_pop = 1'b1;
          end else begin
            w_byte_valid_nxt = 1'b0;
            w_state_nxt      = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Shared frame start: from IDLE, or straight out of CKSUM for
    // back-to-back frames without an idle cycle.
    if (w_pop) begin
      w_shift_nxt      = r_mem[r_rd_ptr];
      w_cksum_nxt      = 8'h00;
      w_byte_nxt       = HEADER;
      w_byte_valid_nxt = 1'b1;
      w_state_nxt      = S_HDR;
    end

    case ({w_capture, w_pop})
      2'b10:   w_count_nxt = r_count + c_CW'(1);
      2'b01:   w_count_nxt = r_count - c_CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_armed      <= 1'b1;
      r_ack        <= 1'b0;
      r_fifo_full  <= 1'b0;
      r_busy       <= 1'b0;
      r_shift      <= '0;
      r_cksum      <= '0;
      r_byte       <= '0;
      r_idx        <= '0;
      r_byte_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_cksum      <= w_cksum_nxt;
      r_byte       <= w_byte_nxt;
      r_idx        <= w_idx_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_count      <= w_count_nxt;
      r_fifo_full  <= (w_count_nxt == c_DEPTH);
      r_busy       <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
      r_ack        <= w_capture;
      if (w_capture) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      // One entry per valid assertion: re-arm only once valid is seen low.
      if (w_capture)           r_armed <= 1'b0;
      else if (!i_result_valid) r_armed <= 1'b1;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge i_CLK) begin
    if (w_capture) r_mem[r_wr_ptr] <= i_result;
  end

  assign o_result_ack = r_ack;
  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_fifo_full  = r_fifo_full;
  assign o_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_notch_result_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_notch_result_packetizer
// Purpose  : Self-checking bench for notch_result_packetizer. Table-driven
//            frame vectors, hand-written multi-cycle corner cases and a
//            randomized run scored against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_notch_result_packetizer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        i_RST = 1'b1;
  logic [31:0] i_result = '0;
  logic        i_result_valid = 1'b0;
  logic        o_result_ack;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready = 1'b0;
  logic        o_fifo_full;
  logic        o_busy;

  always #5 clk = ~clk;

  notch_result_packetizer #(.FIFO_DEPTH(DEPTH), .HEADER(8'hA5)) dut (
    .i_CLK         (clk),
    .i_RST         (i_RST),
    .i_result      (i_result),
    .i_result_valid(i_result_valid),
    .o_result_ack  (o_result_ack),
    .o_byte        (o_byte),
    .o_byte_valid  (o_byte_valid),
    .i_byte_ready  (i_byte_ready),
    .o_fifo_full   (o_fifo_full),
    .o_busy        (o_busy)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         ack_cnt = 0;
  int         ready_mode = 0;   // 0: hold, 1: random, 2: pattern 1,0,0
  logic [7:0] rx_q[$];
  int         rx_cyc[$];
  logic [7:0] exp_q[$];
  bit         acked;
  int         a0;
  logic [31:0] w;
  logic [31:0] words[DEPTH+2];

  typedef struct {
    logic [31:0] word;
    logic [47:0] frame;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock; records every byte handshake that completes at the edge.
  task automatic cycle();
    logic       stall, was_rst;
    logic [7:0] held;
    if (ready_mode == 1) i_byte_ready = ($urandom_range(0, 99) < 60);
    else if (ready_mode == 2) i_byte_ready = ((cyc % 3) == 0);
    stall   = o_byte_valid && !i_byte_ready;
    held    = o_byte;
    was_rst = i_RST;
    if (o_byte_valid && i_byte_ready && !i_RST) begin
      rx_q.push_back(o_byte);
      rx_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (o_result_ack) ack_cnt++;
    if (stall && !was_rst) chk("stall_hold", {o_byte_valid, o_byte}, {1'b1, held});
  endtask

  // Reference model: a frame is header, four bytes MSB first, XOR of them.
  task automatic expect_word(input logic [31:0] x);
    exp_q.push_back(8'hA5);
    exp_q.push_back(x[31:24]);
    exp_q.push_back(x[23:16]);
    exp_q.push_back(x[15:8]);
    exp_q.push_back(x[7:0]);
    exp_q.push_back(x[31:24] ^ x[23:16] ^ x[15:8] ^ x[7:0]);
  endtask

  task automatic compare_rx(input string name);
    chk({name, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({name, "_byte"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
    rx_cyc.delete();
  endtask

  // Present a word and hold it until acked (bounded); valid drops afterwards.
  task automatic offer(input logic [31:0] x, input int bound, output bit got);
    int start;
    start = ack_cnt;
    got = 1'b0;
    i_result = x;
    i_result_valid = 1'b1;
    for (int i = 0; i < bound && !got; i++) begin
      cycle();
      if (ack_cnt != start) got = 1'b1;
    end
    i_result_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((o_busy || o_byte_valid) && n < bound) begin
      cycle();
      n++;
    end
    chk("drain_done", {o_busy, o_byte_valid}, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h3F800000, 48'hA5_3F_80_00_00_BF};
    vecs[1] = '{32'hBE6847E6, 48'hA5_BE_68_47_E6_77};
    vecs[2] = '{32'h3E74375C, 48'hA5_3E_74_37_5C_21};
    vecs[3] = '{32'h12345678, 48'hA5_12_34_56_78_08};
    vecs[4] = '{32'hFFFFFFFF, 48'hA5_FF_FF_FF_FF_00};
    vecs[5] = '{32'h80000001, 48'hA5_80_00_00_01_81};

    // Reset state
    i_RST = 1'b1;
    repeat (3) cycle();
    i_RST = 1'b0;
    chk("rst_ack",   o_result_ack, 1'b0);
    chk("rst_byte",  o_byte, 8'h00);
    chk("rst_valid", o_byte_valid, 1'b0);
    chk("rst_full",  o_fifo_full, 1'b0);
    chk("rst_busy",  o_busy, 1'b0);

    // Table vectors at ready=1: latency, byte values, 6 consecutive cycles
    i_byte_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      a0 = ack_cnt;
      offer(vecs[v].word, 20, acked);
      chk("t1_acked", acked, 1'b1);
      cycle();
      chk("t1_hdr_latency", {o_byte_valid, o_byte}, {1'b1, 8'hA5});
      repeat (6) cycle();
      chk("t1_len", rx_q.size(), 6);
      for (int b = 0; b < 6 && b < rx_q.size(); b++)
        chk("t1_byte", rx_q[b], vecs[v].frame[47-8*b -: 8]);
      chk("t1_idle", {o_byte_valid, o_busy}, 2'b00);
      chk("t1_one_ack", ack_cnt - a0, 1);
      rx_q.delete();
      rx_cyc.delete();
    end

    // Ready toggling 1,0,0: stable bytes under backpressure
    ready_mode = 2;
    offer(32'hBE6847E6, 20, acked);
    chk("t2_acked", acked, 1'b1);
    expect_word(32'hBE6847E6);
    drain(100);
    compare_rx("t2");
    ready_mode = 0;

    // Valid held 10 cycles -> one entry; then re-armed by one low cycle
    i_byte_ready = 1'b1;
    a0 = ack_cnt;
    i_result = 32'h3F800000;
    i_result_valid = 1'b1;
    repeat (10) cycle();
    i_result_valid = 1'b0;
    cycle();
    chk("t3_single_ack", ack_cnt - a0, 1);
    expect_word(32'h3F800000);
    offer(32'h3E74375C, 20, acked);
    chk("t3_second_ack", acked, 1'b1);
    expect_word(32'h3E74375C);
    drain(100);
    chk("t3_total_acks", ack_cnt - a0, 2);
    compare_rx("t3");

    // Backpressure fill: one word sits in the frame register, DEPTH in the FIFO,
    // so DEPTH+1 are acked and the next is held.
    i_byte_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) words[i] = 32'h1000_0000 * (i + 1) + 32'h00A0_0B0C + i;
    for (int i = 0; i < DEPTH + 1; i++) begin
      offer(words[i], 10, acked);
      chk("t4_fill_ack", acked, 1'b1);
      cycle();
    end
    a0 = ack_cnt;
    i_result = words[DEPTH+1];
    i_result_valid = 1'b1;
    repeat (10) cycle();
    chk("t4_held_no_ack", ack_cnt - a0, 0);
    chk("t4_full", o_fifo_full, 1'b1);
    chk("t4_no_bytes", rx_q.size(), 0);
    i_byte_ready = 1'b1;
    acked = 1'b0;
    for (int i = 0; i < 30 && !acked; i++) begin
      cycle();
      if (ack_cnt != a0) acked = 1'b1;
    end
    i_result_valid = 1'b0;
    chk("t4_late_ack", acked, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) expect_word(words[i]);
    drain(300);
    chk("t4_one_late_ack", ack_cnt - a0, 1);
    if (rx_cyc.size() > 0) chk("t4_gapless", rx_cyc[rx_cyc.size()-1] - rx_cyc[0], 6*(DEPTH+2) - 1);
    compare_rx("t4");

    // Capture coinciding with the CKSUM accept that pops the last entry
    i_byte_ready = 1'b0;
    offer(32'hCAFEF00D, 10, acked);
    chk("t5_ack_a", acked, 1'b1);
    cycle();
    offer(32'h01020304, 10, acked);
    chk("t5_ack_b", acked, 1'b1);
    cycle();
    i_byte_ready = 1'b1;
    for (int i = 0; i < 20 && rx_q.size() < 5; i++) cycle();
    chk("t5_at_cksum", rx_q.size(), 5);
    a0 = ack_cnt;
    i_result = 32'hDEADBEEF;
    i_result_valid = 1'b1;
    cycle();
    i_result_valid = 1'b0;
    chk("t5_coincident_ack", ack_cnt - a0, 1);
    chk("t5_next_header", {o_byte_valid, o_byte}, {1'b1, 8'hA5});
    expect_word(32'hCAFEF00D);
    expect_word(32'h01020304);
    expect_word(32'hDEADBEEF);
    drain(100);
    if (rx_cyc.size() > 0) chk("t5_gapless", rx_cyc[rx_cyc.size()-1] - rx_cyc[0], 17);
    compare_rx("t5");

    // Reset during DATA byte 2 with another word queued
    i_byte_ready = 1'b0;
    offer(32'h11223344, 10, acked);
    cycle();
    offer(32'h55667788, 10, acked);
    cycle();
    i_byte_ready = 1'b1;
    for (int i = 0; i < 20 && rx_q.size() < 3; i++) cycle();
    chk("t6_mid_frame", rx_q.size(), 3);
    i_byte_ready = 1'b0;
    i_RST = 1'b1;
    cycle();
    chk("t6_rst_ack",   o_result_ack, 1'b0);
    chk("t6_rst_byte",  o_byte, 8'h00);
    chk("t6_rst_valid", o_byte_valid, 1'b0);
    chk("t6_rst_full",  o_fifo_full, 1'b0);
    chk("t6_rst_busy",  o_busy, 1'b0);
    i_RST = 1'b0;
    i_byte_ready = 1'b1;
    repeat (5) cycle();
    chk("t6_flushed", {rx_q.size() == 3, o_busy, o_byte_valid}, 3'b100);
    rx_q.delete();
    rx_cyc.delete();
    offer(32'h3F800000, 20, acked);
    chk("t6_post_ack", acked, 1'b1);
    expect_word(32'h3F800000);
    drain(100);
    compare_rx("t6");

    // Randomized traffic against the frame model
    ready_mode = 1;
    a0 = ack_cnt;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(1, 3)) cycle();
      w = $urandom;
      offer(w, 300, acked);
      chk("rand_ack", acked, 1'b1);
      expect_word(w);
      i_result_valid = 1'b1;
      repeat ($urandom_range(0, 2)) cycle();
      i_result_valid = 1'b0;
    end
    drain(3000);
    chk("rand_ack_total", ack_cnt - a0, 40);
    compare_rx("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
